// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: N-channel, W-bit registered multiplexer with a valid/ready handshake on
// each channel. A one-entry output register feeds a single consumer through its own
// valid/ready handshake.
// Channel selection has two modes: direct (sel names the channel) and round-robin
// (fair scan of the valid channels).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      async active-low reset
//   mode       0 = direct select, 1 = round-robin
//   sel        channel index, used in direct mode only
//   in_data    channel i occupies bits [i*DATA_W +: DATA_W]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept, one-hot or zero
//   out_data   registered data from the granted channel
//   out_ch     channel index that out_data came from
//   out_valid  the output register holds data
//   out_ready  the consumer accepts out_data this cycle
//
// Output register states:
//   state    | meaning
//   ST_EMPTY | no entry held, out_valid=0
//   ST_FULL  | entry held, out_valid=1, waiting for out_ready
module mux_nto1_rr #(
  parameter  int NUM_CH = 8,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic [SEL_W-1:0]  r_rr_ptr;

  logic              w_load_en;
  logic              w_xfer;
  logic              w_gnt_valid;
  logic [SEL_W-1:0]  w_gnt_ch;
  logic [DATA_W-1:0] w_gnt_data;
  int                w_idx;

  assign w_load_en = (r_state == ST_EMPTY) | out_ready;
  // Gating with rst_n keeps in_ready low for the whole time reset is asserted,
  // not only once the registers have cleared.
  assign w_xfer    = w_load_en & w_gnt_valid & rst_n;

  // Grant. The direct-mode loop compares sel against each real channel index, so
  // a sel value past NUM_CH-1 matches nothing and never indexes outside in_valid.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_ch    = '0;
    w_gnt_data  = '0;
    w_idx       = 0;
    if (!mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          w_gnt_valid = 1'b1;
          w_gnt_ch    = SEL_W'(i);
          w_gnt_data  = in_data[i*DATA_W +: DATA_W];
        end
      end
    end else begin
      // Scan starts one past the last round-robin winner and wraps, so the most
      // recent winner has the lowest priority.
      for (int k = 1; k <= NUM_CH; k++) begin
        w_idx = (int'(r_rr_ptr) + k) % NUM_CH;
        if (!w_gnt_valid && in_valid[w_idx]) begin
          w_gnt_valid = 1'b1;
          w_gnt_ch    = SEL_W'(w_idx);
          w_gnt_data  = in_data[w_idx*DATA_W +: DATA_W];
        end
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state. A load slot with no grant empties the register.
  always_comb begin
    w_state_nxt = r_state;
    if (w_load_en) w_state_nxt = w_gnt_valid ? ST_FULL : ST_EMPTY;
  end

  // FSM: outputs
  always_comb begin
    in_ready  = '0;
    if (w_xfer) in_ready[w_gnt_ch] = 1'b1;
    out_valid = (r_state == ST_FULL);
  end

  // Datapath and round-robin pointer. A direct-mode transfer leaves the pointer
  // unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_ch   <= '0;
      r_rr_ptr   <= SEL_W'(NUM_CH - 1);
    end else if (w_xfer) begin
      r_out_data <= w_gnt_data;
      r_out_ch   <= w_gnt_ch;
      if (mode) r_rr_ptr <= w_gnt_ch;
    end
  end

  assign out_data = r_out_data;
  assign out_ch   = r_out_ch;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb_mux_nto1_rr: directed bench for mux_nto1_rr.
// An 8-channel instance is checked through a scoreboard: the driver queues the
// expected {channel, data} for each predicted transfer. A monitor process pops an
// entry and compares it whenever the output handshake completes.
// A 5-channel instance covers a select value that has no channel.
module tb_mux_nto1_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [2:0]  sel;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic        mode5;
  logic [2:0]  sel5;
  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [7:0]  out_data5;
  logic [2:0]  out_ch5;
  logic        out_valid5;
  logic        out_ready5;

  int checks   = 0;
  int failures = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  mux_nto1_rr #(.NUM_CH(8), .DATA_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nto1_rr #(.NUM_CH(5), .DATA_W(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_ch(out_ch5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = base + 8'(i);
  endtask

  // Scoreboard monitor: one entry leaves the register on each completed output handshake.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_out", {21'd0, out_ch, out_data}, 32'h7ff);
        end else begin
          e = exp_q.pop_front();
          chk("sb_out", {21'd0, out_ch, out_data}, {21'd0, e});
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ch_seq[5];
    logic [7:0] oh;
    rst_n = 1'b0; mode = 1'b1; sel = 3'd0; in_data = '0; in_valid = 8'hFF; out_ready = 1'b0;
    mode5 = 1'b0; sel5 = 3'd0; in_data5 = '0; in_valid5 = '0; out_ready5 = 1'b1;
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'hC0 + 8'(i);

    // Reset state, including in_ready held low while channels are valid.
    #12;
    chk("rst_in_ready", in_ready, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_ch", out_ch, 3'd0);
    in_valid = 8'h00; mode = 1'b0;
    #10 rst_n = 1'b1;
    step();

    // Direct mode, sel=5, only ch5 valid with 0xA5.
    mode = 1'b0; sel = 3'd5; set_data(8'h00); in_data[5*8 +: 8] = 8'hA5;
    in_valid = 8'h20; out_ready = 1'b1;
    at_neg();
    chk("t1_in_ready", in_ready, 8'h20);
    exp_q.push_back({3'd5, 8'hA5});
    step();
    in_valid = 8'h00;
    at_neg();
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_out_data", out_data, 8'hA5);
    chk("t1_out_ch", out_ch, 3'd5);
    step();

    // Round-robin, all valid. The pointer is still 7 after the direct transfer, so
    // grants run ch0..ch7 and wrap to ch0, one per cycle.
    mode = 1'b1; set_data(8'h30); in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      at_neg();
      oh = 8'(1 << (k % 8));
      chk("t2_in_ready", in_ready, oh);
      exp_q.push_back({3'(k % 8), 8'h30 + 8'(k % 8)});
      step();
    end

    // Round-robin, ch2 and ch6 only. The pointer is 0 after the previous wrap.
    set_data(8'h50); in_valid = 8'h44;
    ch_seq = '{8'd2, 8'd6, 8'd2, 8'd6, 8'd2};
    for (int k = 0; k < 5; k++) begin
      at_neg();
      oh = 8'(1 << ch_seq[k]);
      chk("t3_in_ready", in_ready, oh);
      exp_q.push_back({3'(ch_seq[k]), 8'h50 + ch_seq[k]});
      step();
    end

    // Backpressure: the ch2 entry is held for 3 cycles, then ch3 is granted in
    // the same cycle that out_ready rises.
    out_ready = 1'b0; set_data(8'h70); in_valid = 8'h08;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("t4_hold_in_ready", in_ready, 8'h00);
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_data", out_data, 8'h52);
      chk("t4_hold_ch", out_ch, 3'd2);
      step();
    end
    out_ready = 1'b1;
    at_neg();
    chk("t4_release_in_ready", in_ready, 8'h08);
    exp_q.push_back({3'd3, 8'h73});
    step();
    in_valid = 8'h00;
    at_neg();
    chk("t4_new_ch", out_ch, 3'd3);
    chk("t4_new_data", out_data, 8'h73);
    step();
    at_neg();
    chk("t4_drained_valid", out_valid, 1'b0);
    step();

    // 5-channel instance: sel=7 has no channel, so nothing is granted.
    sel5 = 3'd7; in_valid5 = 5'h1F;
    for (int k = 0; k < 2; k++) begin
      at_neg();
      chk("t5_in_ready", in_ready5, 5'h00);
      chk("t5_out_valid", out_valid5, 1'b0);
      step();
    end
    sel5 = 3'd4;
    at_neg();
    chk("t5_sel4_in_ready", in_ready5, 5'h10);
    step();
    in_valid5 = 5'h00;
    at_neg();
    chk("t5_sel4_valid", out_valid5, 1'b1);
    chk("t5_sel4_ch", out_ch5, 3'd4);
    chk("t5_sel4_data", out_data5, 8'hC4);
    step();

    // Reset while FULL discards the entry, and round-robin restarts at ch0.
    mode = 1'b1; out_ready = 1'b0; set_data(8'h90); in_valid = 8'h10;
    at_neg();
    chk("t6_load_in_ready", in_ready, 8'h10);
    exp_q.push_back({3'd4, 8'h94});
    step();
    in_valid = 8'hFF;
    at_neg();
    chk("t6_full_valid", out_valid, 1'b1);
    chk("t6_full_in_ready", in_ready, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_in_ready", in_ready, 8'h00);
    exp_q.delete();
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    at_neg();
    chk("t6_first_rr", in_ready, 8'h01);
    exp_q.push_back({3'd0, 8'h90});
    step();
    at_neg();
    chk("t6_second_rr", in_ready, 8'h02);
    exp_q.push_back({3'd1, 8'h91});
    step();
    in_valid = 8'h00;
    at_neg();
    step();
    at_neg();
    chk("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
